// File: rtl/eth_axis_width_bridge.sv
// eth_axis_width_bridge: AXI-Stream wide<->narrow width bridge honouring per-byte tkeep.
// TX serialises wide beats into narrow lanes (empty lanes skipped); RX packs narrow beats into wide beats.
// Define ETH_BRIDGE_STATS_EN to build the frame/byte statistics counters; otherwise they read 0.
module eth_axis_width_bridge #(
    parameter int WideWidth   = 64,
    parameter int NarrowWidth = 8,
    parameter int UserWidth   = 1,
    parameter int CntWidth    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [WideWidth-1:0]     tx_wide_tdata_i,
    input  logic [WideWidth/8-1:0]   tx_wide_tkeep_i,
    input  logic                     tx_wide_tlast_i,
    input  logic [UserWidth-1:0]     tx_wide_tuser_i,
    input  logic                     tx_wide_tvalid_i,
    output logic                     tx_wide_tready_o,
    output logic [NarrowWidth-1:0]   tx_narrow_tdata_o,
    output logic [NarrowWidth/8-1:0] tx_narrow_tkeep_o,
    output logic                     tx_narrow_tlast_o,
    output logic [UserWidth-1:0]     tx_narrow_tuser_o,
    output logic                     tx_narrow_tvalid_o,
    input  logic                     tx_narrow_tready_i,
    input  logic [NarrowWidth-1:0]   rx_narrow_tdata_i,
    input  logic [NarrowWidth/8-1:0] rx_narrow_tkeep_i,
    input  logic                     rx_narrow_tlast_i,
    input  logic [UserWidth-1:0]     rx_narrow_tuser_i,
    input  logic                     rx_narrow_tvalid_i,
    output logic                     rx_narrow_tready_o,
    output logic [WideWidth-1:0]     rx_wide_tdata_o,
    output logic [WideWidth/8-1:0]   rx_wide_tkeep_o,
    output logic                     rx_wide_tlast_o,
    output logic [UserWidth-1:0]     rx_wide_tuser_o,
    output logic                     rx_wide_tvalid_o,
    input  logic                     rx_wide_tready_i,
    input  logic                     stats_clr_i,
    output logic [CntWidth-1:0]      tx_frames_o,
    output logic [CntWidth-1:0]      tx_bytes_o,
    output logic [CntWidth-1:0]      rx_frames_o,
    output logic [CntWidth-1:0]      rx_bytes_o
);
    localparam int R  = WideWidth / NarrowWidth;
    localparam int NB = NarrowWidth / 8;
    localparam int PW = (R > 1) ? $clog2(R) : 1;
    localparam logic [PW-1:0] LastLane = PW'(R - 1);

    logic ready_en;

    logic                          tx_held_q;
    logic [PW-1:0]                 tx_ptr_q;
    logic [R-1:0][NarrowWidth-1:0] tx_data_q;
    logic [R-1:0][NB-1:0]          tx_keep_q;
    logic                          tx_last_q;
    logic [UserWidth-1:0]          tx_user_q;
    logic [PW-1:0]                 in_first;
    logic [PW-1:0]                 held_next;
    logic                          held_more;
    logic                          in_any;

    logic [R-1:0][NarrowWidth-1:0] acc_data_q;
    logic [R-1:0][NarrowWidth-1:0] acc_data_d;
    logic [R-1:0][NB-1:0]          acc_keep_q;
    logic [R-1:0][NB-1:0]          acc_keep_d;
    logic [UserWidth-1:0]          acc_user_q;
    logic [UserWidth-1:0]          acc_user_d;
    logic [PW-1:0]                 rx_ptr_q;
    logic                          rx_accept;
    logic                          rx_done;
    logic [R-1:0][NarrowWidth-1:0] rx_data_q;
    logic [R-1:0][NB-1:0]          rx_keep_q;
    logic                          rx_last_q;
    logic [UserWidth-1:0]          rx_user_q;
    logic                          rx_valid_q;

    // Both ready outputs stay low for the first cycle after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ready_en <= 1'b0;
        else         ready_en <= 1'b1;
    end

    // Lane bookkeeping: first non-empty lane of the incoming beat, next non-empty lane after the pointer
    always_comb begin
        in_first  = '0;
        held_next = '0;
        held_more = 1'b0;
        for (int i = R - 1; i >= 0; i--) begin
            if (|tx_wide_tkeep_i[i*NB +: NB]) in_first = PW'(i);
            if (|tx_keep_q[i] && PW'(i) > tx_ptr_q) begin
                held_next = PW'(i);
                held_more = 1'b1;
            end
        end
    end

    assign in_any             = |tx_wide_tkeep_i;
    assign tx_wide_tready_o   = ready_en && (!tx_held_q || (!held_more && tx_narrow_tready_i));
    assign tx_narrow_tvalid_o = tx_held_q;
    assign tx_narrow_tdata_o  = tx_data_q[tx_ptr_q];
    assign tx_narrow_tkeep_o  = tx_keep_q[tx_ptr_q];
    assign tx_narrow_tlast_o  = tx_last_q && !held_more;
    assign tx_narrow_tuser_o  = tx_user_q;

    // TX holding register: load a wide beat (all-empty non-last beats vanish), then walk its non-empty lanes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_held_q <= 1'b0;
            tx_ptr_q  <= '0;
            tx_data_q <= '0;
            tx_keep_q <= '0;
            tx_last_q <= 1'b0;
            tx_user_q <= '0;
        end else if (tx_wide_tvalid_i && tx_wide_tready_o) begin
            tx_held_q <= in_any || tx_wide_tlast_i;
            tx_ptr_q  <= in_first;
            tx_data_q <= tx_wide_tdata_i;
            tx_keep_q <= tx_wide_tkeep_i;
            tx_last_q <= tx_wide_tlast_i;
            tx_user_q <= tx_wide_tuser_i;
        end else if (tx_held_q && tx_narrow_tready_i) begin
            tx_held_q <= held_more;
            tx_ptr_q  <= held_more ? held_next : tx_ptr_q;
        end
    end

    // Accumulator contents with the incoming narrow beat merged into the current lane
    always_comb begin
        acc_data_d           = acc_data_q;
        acc_keep_d           = acc_keep_q;
        acc_data_d[rx_ptr_q] = rx_narrow_tdata_i;
        acc_keep_d[rx_ptr_q] = rx_narrow_tkeep_i;
    end

    assign acc_user_d         = acc_user_q | rx_narrow_tuser_i;
    assign rx_narrow_tready_o = ready_en && (!rx_valid_q || rx_wide_tready_i);
    assign rx_accept          = rx_narrow_tvalid_i && rx_narrow_tready_o;
    assign rx_done            = rx_accept && (rx_narrow_tlast_i || rx_ptr_q == LastLane);

    // RX accumulator: lanes above the pointer are always zero, so a cleared accumulator pads short beats
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_data_q <= '0;
            acc_keep_q <= '0;
            acc_user_q <= '0;
            rx_ptr_q   <= '0;
        end else if (rx_done) begin
            acc_data_q <= '0;
            acc_keep_q <= '0;
            acc_user_q <= '0;
            rx_ptr_q   <= '0;
        end else if (rx_accept) begin
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            acc_user_q <= acc_user_d;
            rx_ptr_q   <= rx_ptr_q + PW'(1);
        end
    end

    // RX output register: reloads directly on completion, even in the cycle the previous beat drains
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_keep_q  <= '0;
            rx_last_q  <= 1'b0;
            rx_user_q  <= '0;
        end else if (rx_done) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= acc_data_d;
            rx_keep_q  <= acc_keep_d;
            rx_last_q  <= rx_narrow_tlast_i;
            rx_user_q  <= acc_user_d;
        end else if (rx_wide_tready_i) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign rx_wide_tvalid_o = rx_valid_q;
    assign rx_wide_tdata_o  = rx_data_q;
    assign rx_wide_tkeep_o  = rx_keep_q;
    assign rx_wide_tlast_o  = rx_last_q;
    assign rx_wide_tuser_o  = rx_user_q;

`ifdef ETH_BRIDGE_STATS_EN
    logic                tx_fire;
    logic [CntWidth-1:0] tx_frames_q;
    logic [CntWidth-1:0] tx_bytes_q;
    logic [CntWidth-1:0] rx_frames_q;
    logic [CntWidth-1:0] rx_bytes_q;

    assign tx_fire = tx_narrow_tvalid_o && tx_narrow_tready_i;

    // Narrow-side statistics; clear wins over a same-cycle increment, counters wrap naturally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || stats_clr_i) begin
            tx_frames_q <= '0;
            tx_bytes_q  <= '0;
            rx_frames_q <= '0;
            rx_bytes_q  <= '0;
        end else begin
            if (tx_fire) tx_bytes_q <= tx_bytes_q + CntWidth'($countones(tx_narrow_tkeep_o));
            if (tx_fire && tx_narrow_tlast_o) tx_frames_q <= tx_frames_q + CntWidth'(1);
            if (rx_accept) rx_bytes_q <= rx_bytes_q + CntWidth'($countones(rx_narrow_tkeep_i));
            if (rx_accept && rx_narrow_tlast_i) rx_frames_q <= rx_frames_q + CntWidth'(1);
        end
    end

    assign tx_frames_o = tx_frames_q;
    assign tx_bytes_o  = tx_bytes_q;
    assign rx_frames_o = rx_frames_q;
    assign rx_bytes_o  = rx_bytes_q;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr_i;
    assign tx_frames_o      = '0;
    assign tx_bytes_o       = '0;
    assign rx_frames_o      = '0;
    assign rx_bytes_o       = '0;
`endif
endmodule
